// File: rtl/autosym_expand_eval_if.sv
// Interface bundling the three handshake channels of autosym_expand_eval:
// the configuration request channel, the input-vector channel and the
// result channel, plus the armed/cfg_err status flags.
//   master : driver side (issues config ops, input vectors, accepts results)
//   slave  : evaluator side (autosym_expand_eval)
interface autosym_expand_eval_if #(
  parameter int N_IN = 16,
  parameter int K    = 9,
  parameter int TT_W = 32
);
  localparam int TT_WORDS = (1 << K) / TT_W;
  localparam int ROW_AW   = (K > 1) ? $clog2(K) : 1;
  localparam int WORD_AW  = (TT_WORDS > 1) ? $clog2(TT_WORDS) : 1;
  localparam int ADDR_W   = (ROW_AW > WORD_AW) ? ROW_AW : WORD_AW;
  localparam int DATA_W   = (N_IN > TT_W) ? N_IN : TT_W;

  // configuration channel
  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_op;
  logic [ADDR_W-1:0] cfg_addr;
  logic [DATA_W-1:0] cfg_data;
  // status
  logic              armed;
  logic              cfg_err;
  // input-vector channel
  logic              in_valid;
  logic              in_ready;
  logic [N_IN-1:0]   in_x;
  // result channel
  logic              out_valid;
  logic              out_ready;
  logic [K-1:0]      out_z;
  logic              out_y;

  modport master (
    output cfg_valid, cfg_op, cfg_addr, cfg_data,
    output in_valid, in_x, out_ready,
    input  cfg_ready, armed, cfg_err, in_ready, out_valid, out_z, out_y
  );

  modport slave (
    input  cfg_valid, cfg_op, cfg_addr, cfg_data,
    input  in_valid, in_x, out_ready,
    output cfg_ready, armed, cfg_err, in_ready, out_valid, out_z, out_y
  );
endinterface

// File: rtl/autosym_expand_eval.sv
// autosym_expand_eval: evaluates f(x) = f_k(A.x) over GF(2), the expansion
// of an autosymmetric restriction f_k back to the original N_IN inputs.
// A (K rows of N_IN bits) and the 2^K-bit truth table of f_k are loaded at
// run time through the config channel while disarmed; once armed, input
// vectors stream through a two-stage pipeline:
//   S1: z[i] = parity(A[i] & x)
//   S2: out_z = z, out_y = TT[z]
// Ports:
//   clk  : single rising-edge clock
//   rst  : synchronous active-high reset (clears config, flushes pipeline)
//   bus  : autosym_expand_eval_if.slave (cfg / in / out channels, status)
module autosym_expand_eval #(
  parameter int N_IN = 16,
  parameter int K    = 9,
  parameter int TT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  autosym_expand_eval_if.slave bus
);
  localparam int TT_BITS  = 1 << K;
  localparam int TT_WORDS = TT_BITS / TT_W;
  localparam int BIT_AW   = $clog2(TT_W);
  localparam int ROW_AW   = (K > 1) ? $clog2(K) : 1;
  localparam int WORD_AW  = (TT_WORDS > 1) ? $clog2(TT_WORDS) : 1;
  localparam int ADDR_W   = (ROW_AW > WORD_AW) ? ROW_AW : WORD_AW;

  // Address limits widened by one bit so the range checks cannot wrap.
  localparam logic [ADDR_W:0] ROW_LIM  = (ADDR_W + 1)'(K);
  localparam logic [ADDR_W:0] WORD_LIM = (ADDR_W + 1)'(TT_WORDS);

  localparam logic [1:0] OP_ROW    = 2'd0;
  localparam logic [1:0] OP_TT     = 2'd1;
  localparam logic [1:0] OP_ARM    = 2'd2;
  localparam logic [1:0] OP_DISARM = 2'd3;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_DRAIN    = 2'd2
  } state_t;

  state_t       state_reg;
  logic         armed_reg;
  logic         cfg_err_reg;

  logic         s1_valid_reg;
  logic [K-1:0] s1_z_reg;
  logic         s2_valid_reg;
  logic [K-1:0] out_z_reg;
  logic         out_y_reg;

  logic [K-1:0]      z_next;
  logic [TT_W-1:0]   tt_words [TT_WORDS];

  logic              cfg_fire;
  logic              in_fire;
  logic              s2_load;
  logic              is_disarmed;
  logic              is_armed;
  logic              row_ok;
  logic              word_ok;
  logic              row_we;
  logic              tt_we;
  logic              err_set;
  logic              arm_go;
  logic              disarm_go;
  logic              pipe_empty;

  // ---------------------------------------------------------------------
  // Handshake and config decode
  // ---------------------------------------------------------------------
  assign is_disarmed = (state_reg == ST_DISARMED);
  assign is_armed    = (state_reg == ST_ARMED);

  // Config is refused only while the pipeline drains after a disarm.
  assign bus.cfg_ready = (state_reg != ST_DRAIN);
  assign cfg_fire      = bus.cfg_valid & bus.cfg_ready;

  // S2 can take new data when empty or when its result leaves this cycle.
  assign s2_load      = ~s2_valid_reg | bus.out_ready;
  assign bus.in_ready = is_armed & (~s1_valid_reg | s2_load);
  assign in_fire      = bus.in_valid & bus.in_ready;

  assign row_ok  = ({1'b0, bus.cfg_addr} < ROW_LIM);
  assign word_ok = ({1'b0, bus.cfg_addr} < WORD_LIM);

  assign row_we    = cfg_fire & is_disarmed & (bus.cfg_op == OP_ROW) & row_ok;
  assign tt_we     = cfg_fire & is_disarmed & (bus.cfg_op == OP_TT) & word_ok;
  assign arm_go    = cfg_fire & is_disarmed & (bus.cfg_op == OP_ARM);
  assign disarm_go = cfg_fire & is_armed & (bus.cfg_op == OP_DISARM);

  // Errors: out-of-range writes while disarmed, or any non-disarm op while
  // armed (those are accepted but have no effect on A or the table).
  assign err_set = cfg_fire & (
      (is_disarmed & (bus.cfg_op == OP_ROW) & ~row_ok) |
      (is_disarmed & (bus.cfg_op == OP_TT)  & ~word_ok) |
      (is_armed    & (bus.cfg_op != OP_DISARM)));

  assign pipe_empty = ~s1_valid_reg & ~s2_valid_reg;

  // ---------------------------------------------------------------------
  // Matrix rows: each row owns its register and its GF(2) dot product.
  // ---------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_row
      logic [N_IN-1:0] row_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          row_reg <= '0;
        end else if (row_we && (bus.cfg_addr == ADDR_W'(gi))) begin
          row_reg <= bus.cfg_data[N_IN-1:0];
        end
      end

      assign z_next[gi] = ^(row_reg & bus.in_x);
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Truth table: TT_WORDS words of TT_W bits, word w holds TT bits
  // [w*TT_W +: TT_W]; bit z lives in word z[K-1:BIT_AW], bit z[BIT_AW-1:0].
  // ---------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < TT_WORDS; gi++) begin : g_tt
      logic [TT_W-1:0] word_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          word_reg <= '0;
        end else if (tt_we && (bus.cfg_addr == ADDR_W'(gi))) begin
          word_reg <= bus.cfg_data[TT_W-1:0];
        end
      end

      assign tt_words[gi] = word_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_DISARMED;
      armed_reg   <= 1'b0;
      cfg_err_reg <= 1'b0;
    end else begin
      if (err_set) begin
        cfg_err_reg <= 1'b1;
      end
      case (state_reg)
        ST_DISARMED: begin
          if (arm_go) begin
            state_reg <= ST_ARMED;
            armed_reg <= 1'b1;
          end
        end
        ST_ARMED: begin
          // A vector accepted in the same cycle as the disarm is already
          // in S1 next cycle, so DRAIN waits for it.
          if (disarm_go) begin
            state_reg <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pipe_empty) begin
            state_reg <= ST_DISARMED;
            armed_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_DISARMED;
          armed_reg <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Evaluation pipeline
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_z_reg     <= '0;
      s2_valid_reg <= 1'b0;
      out_z_reg    <= '0;
      out_y_reg    <= 1'b0;
    end else begin
      // S2 only changes when it may load, so a stalled result stays put.
      if (s2_load) begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          out_z_reg <= s1_z_reg;
          out_y_reg <= tt_words[s1_z_reg[K-1:BIT_AW]][s1_z_reg[BIT_AW-1:0]];
        end
      end

      if (in_fire) begin
        s1_valid_reg <= 1'b1;
        s1_z_reg     <= z_next;
      end else if (s2_load) begin
        s1_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.armed     = armed_reg;
  assign bus.cfg_err   = cfg_err_reg;
  assign bus.out_valid = s2_valid_reg;
  assign bus.out_z     = out_z_reg;
  assign bus.out_y     = out_y_reg;

endmodule

// File: tb/tb_autosym_expand_eval.sv
// Self-checking bench for autosym_expand_eval. A reference model holds the
// matrix rows and the truth table as plain arrays and evaluates
// f(x) = TT[A.x] with population-count parity.
module tb_autosym_expand_eval;
  localparam int N_IN     = 16;
  localparam int K        = 9;
  localparam int TT_W     = 32;
  localparam int TT_BITS  = 1 << K;
  localparam int TT_WORDS = TT_BITS / TT_W;
  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  autosym_expand_eval_if #(.N_IN(N_IN), .K(K), .TT_W(TT_W)) bus ();

  autosym_expand_eval #(.N_IN(N_IN), .K(K), .TT_W(TT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ------------------------------------------------------------------
  // Reference model
  // ------------------------------------------------------------------
  logic [N_IN-1:0]    m_rows [K];
  logic [TT_BITS-1:0] m_tt;
  bit                 m_armed;

  function automatic void model_clear();
    for (int i = 0; i < K; i++) m_rows[i] = '0;
    m_tt    = '0;
    m_armed = 0;
  endfunction

  // Returns {y, z}.
  function automatic logic [K:0] model_eval(input logic [N_IN-1:0] x);
    logic [K-1:0] z;
    for (int i = 0; i < K; i++) z[i] = ($countones(m_rows[i] & x) % 2) == 1;
    return {m_tt[z], z};
  endfunction

  // ------------------------------------------------------------------
  // Stimulus helpers (all start and end 1 time unit after a rising edge)
  // ------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_do(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] data);
    int w = 0;
    bus.cfg_valid = 1'b1;
    bus.cfg_op    = op;
    bus.cfg_addr  = addr;
    bus.cfg_data  = data;
    #1;
    while (!bus.cfg_ready && w < 20) begin
      tick();
      w++;
    end
    if (!bus.cfg_ready) begin
      total++;
      bad++;
      $display("FAIL cfg_accept op=%0d: cfg_ready=%b required 1", op, bus.cfg_ready);
    end else if (!m_armed) begin
      case (op)
        2'd0: if (int'(addr) < K) m_rows[addr] = data[N_IN-1:0];
        2'd1: if (int'(addr) < TT_WORDS) m_tt[int'(addr)*TT_W +: TT_W] = data;
        2'd2: m_armed = 1;
        default: ;
      endcase
    end
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic disarm();
    int w = 0;
    cfg_do(2'd3, '0, '0);
    while (bus.armed && w < 20) begin
      tick();
      w++;
    end
    total++;
    if (bus.armed !== 1'b0) begin
      bad++;
      $display("FAIL disarm_done: armed=%b required 0", bus.armed);
    end
    m_armed = 0;
  endtask

  task automatic load_random_config();
    for (int i = 0; i < K; i++) cfg_do(2'd0, ADDR_W'(i), DATA_W'($urandom));
    for (int w = 0; w < TT_WORDS; w++) cfg_do(2'd1, ADDR_W'(w), DATA_W'($urandom));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.cfg_valid = 1'b0;
    bus.in_valid  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    model_clear();
  endtask

  // Streams n random vectors, holding out_ready low for stall_len cycles
  // starting at cycle stall_at, and scores results in order.
  task automatic run_stream(input int n, input int stall_at, input int stall_len,
                            input string tag);
    logic [K:0]      exp_q [$];
    logic [K:0]      e;
    logic [N_IN-1:0] x = N_IN'($urandom);
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    bit blocked = 0;
    while (got < n && cyc < 200) begin
      bus.in_valid  = (sent < n);
      bus.in_x      = x;
      bus.out_ready = !(stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len);
      #1;
      if (bus.in_valid && !bus.in_ready) blocked = 1;
      if (bus.out_valid && bus.out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL %s_extra: unexpected result z=%h y=%b", tag, bus.out_z, bus.out_y);
        end else begin
          e = exp_q.pop_front();
          if ({bus.out_y, bus.out_z} !== e) begin
            bad++;
            $display("FAIL %s_result%0d: got z=%h y=%b required z=%h y=%b",
                     tag, got, bus.out_z, bus.out_y, e[K-1:0], e[K]);
          end
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model_eval(x));
        sent++;
        x = N_IN'($urandom);
      end
      tick();
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    total++;
    if (got != n) begin
      bad++;
      $display("FAIL %s_count: got %0d results required %0d", tag, got, n);
    end
    if (stall_len > 0) begin
      total++;
      if (!blocked) begin
        bad++;
        $display("FAIL %s_backpressure: in_ready never dropped, required a drop", tag);
      end
    end
    #1;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_tail: out_valid=%b required 0", tag, bus.out_valid);
    end
    tick();
  endtask

  // ------------------------------------------------------------------
  // Tests
  // ------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    total++;
    if ({bus.armed, bus.cfg_err, bus.out_valid, bus.out_y} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags: armed=%b cfg_err=%b out_valid=%b out_y=%b required all 0",
               bus.armed, bus.cfg_err, bus.out_valid, bus.out_y);
    end
    total++;
    if (bus.out_z !== '0) begin
      bad++;
      $display("FAIL reset_out_z: got %h required 0", bus.out_z);
    end
    bus.in_valid = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b0 || bus.cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: in_ready=%b cfg_ready=%b required 0/1",
               bus.in_ready, bus.cfg_ready);
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_identity();
    logic [N_IN-1:0] xs [2];
    logic [K:0]      e;
    xs[0] = 16'h0005;
    xs[1] = 16'h0006;
    for (int i = 0; i < K; i++) cfg_do(2'd0, ADDR_W'(i), DATA_W'(1 << i));
    for (int w = 0; w < TT_WORDS; w++) cfg_do(2'd1, ADDR_W'(w), (w == 0) ? 32'h20 : 32'h0);
    cfg_do(2'd2, '0, '0);
    total++;
    if (bus.armed !== 1'b1) begin
      bad++;
      $display("FAIL identity_arm: armed=%b required 1", bus.armed);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      e = model_eval(xs[i]);
      bus.in_x     = xs[i];
      bus.in_valid = 1'b1;
      #1;
      total++;
      if (bus.in_ready !== 1'b1) begin
        bad++;
        $display("FAIL identity_in_ready%0d: got %b required 1", i, bus.in_ready);
      end
      tick();
      bus.in_valid = 1'b0;
      #1;
      total++;
      if (bus.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL identity_early%0d: out_valid=%b required 0 at t+1", i, bus.out_valid);
      end
      tick();
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_z !== e[K-1:0] || bus.out_y !== e[K]) begin
        bad++;
        $display("FAIL identity_x%h: got v=%b z=%h y=%b required v=1 z=%h y=%b",
                 xs[i], bus.out_valid, bus.out_z, bus.out_y, e[K-1:0], e[K]);
      end
      tick();
    end
  endtask

  task automatic test_parity();
    logic [N_IN-1:0] xs [2];
    logic [K:0]      e;
    xs[0] = 16'h0001;
    xs[1] = 16'h0003;
    disarm();
    for (int i = 0; i < K; i++) cfg_do(2'd0, ADDR_W'(i), (i == 0) ? 32'hFFFF : 32'h0);
    for (int w = 0; w < TT_WORDS; w++) cfg_do(2'd1, ADDR_W'(w), (w == 0) ? 32'h2 : 32'h0);
    cfg_do(2'd2, '0, '0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      e = model_eval(xs[i]);
      bus.in_x     = xs[i];
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_z !== e[K-1:0] || bus.out_y !== e[K]) begin
        bad++;
        $display("FAIL parity_x%h: got v=%b z=%h y=%b required v=1 z=%h y=%b",
                 xs[i], bus.out_valid, bus.out_z, bus.out_y, e[K-1:0], e[K]);
      end
      tick();
    end
    run_stream(6, 0, 0, "parity_rand");
  endtask

  task automatic test_back_to_back();
    disarm();
    load_random_config();
    cfg_do(2'd2, '0, '0);
    run_stream(8, 3, 3, "b2b");
  endtask

  task automatic test_cfg_err();
    // Writes while armed are accepted but ignored and flag an error.
    cfg_do(2'd0, '0, DATA_W'($urandom));
    total++;
    if (bus.cfg_err !== 1'b1) begin
      bad++;
      $display("FAIL err_armed_write: cfg_err=%b required 1", bus.cfg_err);
    end
    cfg_do(2'd1, ADDR_W'(3), DATA_W'($urandom));
    cfg_do(2'd2, '0, '0);
    run_stream(6, 0, 0, "err_armed");
    do_reset();
    total++;
    if (bus.cfg_err !== 1'b0 || bus.armed !== 1'b0) begin
      bad++;
      $display("FAIL err_reset_clear: cfg_err=%b armed=%b required 0/0", bus.cfg_err, bus.armed);
    end
    // Out-of-range row addresses while disarmed.
    load_random_config();
    total++;
    if (bus.cfg_err !== 1'b0) begin
      bad++;
      $display("FAIL err_legal_writes: cfg_err=%b required 0", bus.cfg_err);
    end
    cfg_do(2'd0, ADDR_W'(K), DATA_W'($urandom));
    cfg_do(2'd0, ADDR_W'(15), DATA_W'($urandom));
    total++;
    if (bus.cfg_err !== 1'b1) begin
      bad++;
      $display("FAIL err_row_range: cfg_err=%b required 1", bus.cfg_err);
    end
    cfg_do(2'd2, '0, '0);
    run_stream(6, 0, 0, "err_range");
  endtask

  task automatic test_disarm_inflight();
    logic [K:0]      exp_q [$];
    logic [K:0]      e;
    logic [N_IN-1:0] x;
    int got = 0;
    int cyc = 0;
    bus.out_ready = 1'b0;
    x = N_IN'($urandom);
    bus.in_x     = x;
    bus.in_valid = 1'b1;
    #1;
    if (bus.in_ready) exp_q.push_back(model_eval(x));
    tick();
    // Second vector accepted in the same cycle as the disarm request.
    x = N_IN'($urandom);
    bus.in_x      = x;
    bus.cfg_valid = 1'b1;
    bus.cfg_op    = 2'd3;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    #1;
    total++;
    if (bus.in_ready !== 1'b1 || bus.cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL drain_accept: in_ready=%b cfg_ready=%b required 1/1",
               bus.in_ready, bus.cfg_ready);
    end
    if (bus.in_ready) exp_q.push_back(model_eval(x));
    tick();
    bus.in_valid  = 1'b0;
    bus.cfg_valid = 1'b0;
    tick();
    total++;
    if (bus.in_ready !== 1'b0 || bus.cfg_ready !== 1'b0 || bus.armed !== 1'b1 ||
        bus.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL drain_state: in_ready=%b cfg_ready=%b armed=%b out_valid=%b required 0/0/1/1",
               bus.in_ready, bus.cfg_ready, bus.armed, bus.out_valid);
    end
    e = exp_q[0];
    total++;
    if (bus.out_z !== e[K-1:0] || bus.out_y !== e[K]) begin
      bad++;
      $display("FAIL drain_hold: z=%h y=%b required z=%h y=%b",
               bus.out_z, bus.out_y, e[K-1:0], e[K]);
    end
    bus.out_ready = 1'b1;
    while ((bus.armed || got < 2) && cyc < 20) begin
      bus.in_valid = 1'b1;
      #1;
      if (bus.armed && bus.in_ready !== 1'b0) begin
        total++;
        bad++;
        $display("FAIL drain_in_ready: in_ready=%b required 0", bus.in_ready);
      end
      if (bus.out_valid && bus.out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL drain_extra: z=%h y=%b", bus.out_z, bus.out_y);
        end else begin
          e = exp_q.pop_front();
          if ({bus.out_y, bus.out_z} !== e || bus.armed !== 1'b1) begin
            bad++;
            $display("FAIL drain_result%0d: z=%h y=%b armed=%b required z=%h y=%b armed=1",
                     got, bus.out_z, bus.out_y, bus.armed, e[K-1:0], e[K]);
          end
        end
        got++;
      end
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    m_armed = 0;
    total++;
    if (got != 2 || bus.armed !== 1'b0 || bus.cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL drain_done: results=%0d armed=%b cfg_ready=%b required 2/0/1",
               got, bus.armed, bus.cfg_ready);
    end
  endtask

  task automatic test_reset_inflight();
    load_random_config();
    cfg_do(2'd2, '0, '0);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_x      = N_IN'($urandom);
    tick();
    bus.in_x      = N_IN'($urandom);
    tick();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    total++;
    if (bus.out_valid !== 1'b0 || bus.armed !== 1'b0 || bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_flush: out_valid=%b armed=%b in_ready=%b required 0/0/0",
               bus.out_valid, bus.armed, bus.in_ready);
    end
    rst = 1'b0;
    model_clear();
    bus.out_ready = 1'b1;
    tick();
    total++;
    if (bus.out_valid !== 1'b0 || bus.cfg_err !== 1'b0) begin
      bad++;
      $display("FAIL rst_after: out_valid=%b cfg_err=%b required 0/0", bus.out_valid, bus.cfg_err);
    end
    cfg_do(2'd2, '0, '0);
    run_stream(4, 0, 0, "rst_zero_cfg");
  endtask

  initial begin
    bus.cfg_valid = 1'b0;
    bus.cfg_op    = '0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.out_ready = 1'b1;
    model_clear();
    #1;
    test_reset();
    test_identity();
    test_parity();
    test_back_to_back();
    test_cfg_err();
    test_disarm_inflight();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
